// File: rtl/pipe_ctrl_md.sv
// pipe_ctrl_md: RV32IM pipelined control unit. Decodes in Decode, carries control through the
// Execute/Memory/Writeback control registers, resolves conditional branches in Execute and
// sequences multi-cycle multiply/divide operations with a stall request to the hazard unit.
module pipe_ctrl_md #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned ALUC_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              ZeroE,
    input  logic              NegE,
    input  logic              OverflowE,
    input  logic              CarryE,
    input  logic              FlushE,
    input  logic              StallE,
    output logic [2:0]        ImmSrcD,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              ALUSrcAE,
    output logic [1:0]        ALUSrcBE,
    output logic              PCJalSrcE,
    output logic              PCSrcE,
    output logic              ResultSrcEb0,
    output logic              MdStartE,
    output logic [2:0]        MdOpE,
    output logic              MdStallReq,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [2:0]        MemWidthM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] MdFunct7 = 7'b0000001;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOr    = 4'd3;
    localparam logic [3:0] AluXor   = 4'd4;
    localparam logic [3:0] AluSlt   = 4'd5;
    localparam logic [3:0] AluSltu  = 4'd6;
    localparam logic [3:0] AluSll   = 4'd7;
    localparam logic [3:0] AluSrl   = 4'd8;
    localparam logic [3:0] AluSra   = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);
    // Last counter value of each operation class (occupancy minus one).
    localparam logic [CntW-1:0] MulLast = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(DIV_CYCLES - 1);

    typedef struct packed {
        logic              regWrite;
        logic [1:0]        resultSrc;
        logic              memWrite;
        logic              jump;
        logic              branch;
        logic [ALUC_W-1:0] aluControl;
        logic              aluSrcA;
        logic [1:0]        aluSrcB;
        logic              pcJalSrc;
        logic [2:0]        funct3;
        logic              mdValid;
    } execCtrlT;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic [1:0] resultSrc;
        logic [2:0] funct3;
    } memCtrlT;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
    } wbCtrlT;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mdStateT;

    execCtrlT        ctrlD;
    execCtrlT        ctrlE;
    memCtrlT         ctrlM;
    wbCtrlT          ctrlW;
    logic [1:0]      aluOpD;
    logic            branchTaken;
    logic            holdE;
    logic [CntW-1:0] lastE;
    logic [CntW-1:0] mdCnt;
    mdStateT         mdState;

    function automatic logic [3:0] aluDecode(input logic [1:0] aluOp, input logic [2:0] f3,
                                             input logic f7b5, input logic opb5);
        logic [3:0] code;
        code = AluAdd;
        case (aluOp)
            2'b00:   code = AluAdd;
            2'b01:   code = AluSub;
            2'b11:   code = AluPassB;
            default: begin
                case (f3)
                    3'b000:  code = (f7b5 & opb5) ? AluSub : AluAdd;
                    3'b001:  code = AluSll;
                    3'b010:  code = AluSlt;
                    3'b011:  code = AluSltu;
                    3'b100:  code = AluXor;
                    3'b101:  code = f7b5 ? AluSra : AluSrl;
                    3'b110:  code = AluOr;
                    default: code = AluAnd;
                endcase
            end
        endcase
        return code;
    endfunction

    // Main and ALU decode of the Decode-stage instruction.
    always_comb begin
        ctrlD        = '0;
        ImmSrcD      = 3'b000;
        aluOpD       = 2'b00;
        ctrlD.funct3 = funct3;
        case (op)
            OpLoad: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = 2'b01;
                ctrlD.aluSrcB   = 2'b01;
            end
            OpStore: begin
                ctrlD.memWrite = 1'b1;
                ctrlD.aluSrcB  = 2'b01;
                ImmSrcD        = 3'b001;
            end
            OpReg: begin
                ctrlD.regWrite = 1'b1;
                if (funct7 == MdFunct7) begin
                    ctrlD.resultSrc = 2'b11;
                    ctrlD.mdValid   = 1'b1;
                end else begin
                    aluOpD = 2'b10;
                end
            end
            OpImm: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrcB  = 2'b01;
                aluOpD         = 2'b10;
            end
            OpBranch: begin
                ctrlD.branch = 1'b1;
                ImmSrcD      = 3'b010;
                aluOpD       = 2'b01;
            end
            OpJal: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = 2'b10;
                ctrlD.jump      = 1'b1;
                ImmSrcD         = 3'b011;
            end
            OpJalr: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = 2'b10;
                ctrlD.jump      = 1'b1;
                ctrlD.pcJalSrc  = 1'b1;
                ctrlD.aluSrcB   = 2'b01;
            end
            OpLui: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrcB  = 2'b01;
                ImmSrcD        = 3'b100;
                aluOpD         = 2'b11;
            end
            OpAuipc: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrcA  = 1'b1;
                ctrlD.aluSrcB  = 2'b01;
                ImmSrcD        = 3'b100;
            end
            default: ;
        endcase
        ctrlD.aluControl = ALUC_W'(aluDecode(aluOpD, funct3, funct7[5], op[5]));
    end

    // Branch resolution from the a-b flags; CarryE high means no borrow.
    always_comb begin
        case (ctrlE.funct3)
            3'b000:  branchTaken = ZeroE;
            3'b001:  branchTaken = ~ZeroE;
            3'b100:  branchTaken = NegE ^ OverflowE;
            3'b101:  branchTaken = ~(NegE ^ OverflowE);
            3'b110:  branchTaken = ~CarryE;
            3'b111:  branchTaken = CarryE;
            default: branchTaken = 1'b0;
        endcase
        PCSrcE = ctrlE.jump | (ctrlE.branch & branchTaken);
    end

    assign lastE = ctrlE.funct3[2] ? DivLast : MulLast;

    // A new M-ext op starts in Idle; Done marks a finished op parked behind an external stall.
    always_comb begin
        MdStartE   = (mdState == StIdle) & ctrlE.mdValid;
        MdStallReq = ctrlE.mdValid & (((mdState == StIdle) & (lastE != '0)) |
                                      ((mdState == StBusy) & (mdCnt < lastE)));
        holdE      = StallE | MdStallReq;
    end

    // Multiply/divide sequencer: counts Execute occupancy of the current M-ext instruction.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            mdState <= StIdle;
            mdCnt   <= '0;
        end else begin
            case (mdState)
                StIdle: begin
                    if (ctrlE.mdValid) begin
                        if (lastE == '0) begin
                            if (StallE) mdState <= StDone;
                        end else begin
                            mdState <= StBusy;
                            mdCnt   <= CntW'(1);
                        end
                    end
                end
                StBusy: begin
                    if (mdCnt < lastE) begin
                        mdCnt <= mdCnt + 1'b1;
                    end else begin
                        mdCnt   <= '0;
                        mdState <= StallE ? StDone : StIdle;
                    end
                end
                StDone: begin
                    if (!StallE) mdState <= StIdle;
                end
                default: begin
                    mdState <= StIdle;
                    mdCnt   <= '0;
                end
            endcase
        end
    end

    // Execute control register: flush bubbles, hold keeps the instruction in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlE <= '0;
        end else if (FlushE) begin
            ctrlE <= '0;
        end else if (!holdE) begin
            ctrlE <= ctrlD;
        end
    end

    // Memory control register: a held Execute stage sends a bubble downstream.
    always_ff @(posedge clk) begin
        if (reset || holdE) begin
            ctrlM <= '0;
        end else begin
            ctrlM <= '{regWrite:  ctrlE.regWrite,
                       memWrite:  ctrlE.memWrite,
                       resultSrc: ctrlE.resultSrc,
                       funct3:    ctrlE.funct3};
        end
    end

    // Writeback control register follows Memory every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlW <= '0;
        end else begin
            ctrlW <= '{regWrite: ctrlM.regWrite, resultSrc: ctrlM.resultSrc};
        end
    end

    assign ALUControlE  = ctrlE.aluControl;
    assign ALUSrcAE     = ctrlE.aluSrcA;
    assign ALUSrcBE     = ctrlE.aluSrcB;
    assign PCJalSrcE    = ctrlE.pcJalSrc;
    assign ResultSrcEb0 = ctrlE.resultSrc[0];
    assign MdOpE        = ctrlE.mdValid ? ctrlE.funct3 : 3'b000;
    assign RegWriteM    = ctrlM.regWrite;
    assign MemWriteM    = ctrlM.memWrite;
    assign MemWidthM    = ctrlM.funct3;
    assign RegWriteW    = ctrlW.regWrite;
    assign ResultSrcW   = ctrlW.resultSrc;

endmodule

// File: tb/tb_pipe_ctrl_md.sv
// tb_pipe_ctrl_md: directed scenarios plus randomized traffic for pipe_ctrl_md, checked against
// an instruction-level reference model (work-remaining per Execute occupant, flags from a-b).
module tb_pipe_ctrl_md;

    localparam int unsigned MulCyc = 1;
    localparam int unsigned DivCyc = 33;
    localparam int unsigned AlucW  = 4;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpNop    = 7'b0000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, ZeroE, NegE, OverflowE, CarryE, FlushE, StallE;
    logic [6:0]       op, funct7;
    logic [2:0]       funct3;
    logic [2:0]       ImmSrcD, MdOpE, MemWidthM;
    logic [AlucW-1:0] ALUControlE;
    logic             ALUSrcAE, PCJalSrcE, PCSrcE, ResultSrcEb0, MdStartE, MdStallReq;
    logic [1:0]       ALUSrcBE, ResultSrcW;
    logic             RegWriteM, MemWriteM, RegWriteW;

    pipe_ctrl_md #(
        .MUL_CYCLES(MulCyc),
        .DIV_CYCLES(DivCyc),
        .ALUC_W    (AlucW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .ZeroE       (ZeroE),
        .NegE        (NegE),
        .OverflowE   (OverflowE),
        .CarryE      (CarryE),
        .FlushE      (FlushE),
        .StallE      (StallE),
        .ImmSrcD     (ImmSrcD),
        .ALUControlE (ALUControlE),
        .ALUSrcAE    (ALUSrcAE),
        .ALUSrcBE    (ALUSrcBE),
        .PCJalSrcE   (PCJalSrcE),
        .PCSrcE      (PCSrcE),
        .ResultSrcEb0(ResultSrcEb0),
        .MdStartE    (MdStartE),
        .MdOpE       (MdOpE),
        .MdStallReq  (MdStallReq),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .MemWidthM   (MemWidthM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW)
    );

    int nVec = 0;
    int nErr = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level view of the control carried down the pipe.
    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic [1:0] resultSrc;
        logic       branch;
        logic       jump;
        logic [2:0] f3;
        logic       isMd;
        logic [2:0] imm;
    } instT;

    instT mE = '0;
    instT mM = '0;
    instT mW = '0;
    int   mWork = 0;   // Execute cycles already spent by the current M-ext occupant

    function automatic instT decodeRef(input logic [6:0] o, input logic [2:0] f3,
                                       input logic [6:0] f7);
        instT d;
        d    = '0;
        d.f3 = f3;
        case (o)
            OpLoad:  begin d.regWrite = 1'b1; d.resultSrc = 2'b01; end
            OpStore: begin d.memWrite = 1'b1; d.imm = 3'b001; end
            OpReg: begin
                d.regWrite = 1'b1;
                if (f7 == 7'b0000001) begin d.isMd = 1'b1; d.resultSrc = 2'b11; end
            end
            OpImm:    d.regWrite = 1'b1;
            OpBranch: begin d.branch = 1'b1; d.imm = 3'b010; end
            OpJal:    begin d.regWrite = 1'b1; d.resultSrc = 2'b10; d.jump = 1'b1; d.imm = 3'b011; end
            OpJalr:   begin d.regWrite = 1'b1; d.resultSrc = 2'b10; d.jump = 1'b1; end
            OpLui, OpAuipc: begin d.regWrite = 1'b1; d.imm = 3'b100; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic takenRef(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive inputs after the falling edge, compare, then advance the model.
    task automatic runCycle(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                            input logic stl, input logic fl, input logic chk);
        logic [32:0] diff;
        int          n;
        logic        expStart, expStall, held;
        instT        dD;
        @(negedge clk);
        diff      = {1'b0, a} + {1'b0, ~b} + 33'd1;
        reset     = rst;
        op        = o;
        funct3    = f3;
        funct7    = f7;
        ZeroE     = (diff[31:0] == 32'd0);
        NegE      = diff[31];
        OverflowE = (a[31] != b[31]) && (diff[31] != a[31]);
        CarryE    = diff[32];
        StallE    = stl;
        FlushE    = fl;
        #1;
        dD       = decodeRef(o, f3, f7);
        n        = mE.f3[2] ? int'(DivCyc) : int'(MulCyc);
        expStart = mE.isMd && (mWork == 0);
        expStall = mE.isMd && (mWork + 1 < n);
        if (chk) begin
            checkVal("immsrc",   32'(ImmSrcD),      32'(dD.imm));
            checkVal("pcsrc",    32'(PCSrcE),       32'(mE.jump | (mE.branch & takenRef(mE.f3, a, b))));
            checkVal("ressrc0",  32'(ResultSrcEb0), 32'(mE.resultSrc[0]));
            checkVal("mdstart",  32'(MdStartE),     32'(expStart));
            checkVal("mdop",     32'(MdOpE),        32'(mE.isMd ? mE.f3 : 3'b000));
            checkVal("mdstall",  32'(MdStallReq),   32'(expStall));
            checkVal("regwrm",   32'(RegWriteM),    32'(mM.regWrite));
            checkVal("memwrm",   32'(MemWriteM),    32'(mM.memWrite));
            checkVal("memwidth", 32'(MemWidthM),    32'(mM.f3));
            checkVal("regwrw",   32'(RegWriteW),    32'(mW.regWrite));
            checkVal("ressrcw",  32'(ResultSrcW),   32'(mW.resultSrc));
        end
        held = stl | expStall;
        if (rst) begin
            mE = '0; mM = '0; mW = '0; mWork = 0;
        end else begin
            mW = mM;
            mM = held ? '0 : mE;
            if (fl) begin
                mE = '0; mWork = 0;
            end else if (held) begin
                if (mE.isMd && mWork < n) mWork++;
            end else begin
                mE = dD; mWork = 0;
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) runCycle(1'b0, OpNop, 3'b000, 7'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic branchCase(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic exp);
        runCycle(1'b0, OpBranch, f3, 7'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        runCycle(1'b0, OpNop, 3'b000, 7'd0, a, b, 1'b0, 1'b0, 1'b1);
        checkVal(tag, 32'(PCSrcE), 32'(exp));
    endtask

    logic [1:0] sTrace [64];
    logic [2:0] wTrace [64];
    int         starts, stalls, firstM, firstW;
    logic [1:0] resW;

    // M-ext op in Decode at cycle 0, op1 at cycle 1, then NOPs; records per-cycle traces.
    task automatic mdSeq(input logic [2:0] f3, input logic [6:0] op1, input int stFrom,
                         input int stTo, input int flAt, input int rsAt, input int len);
        starts = 0; stalls = 0; firstM = -1; firstW = -1; resW = 2'b00;
        for (int c = 0; c < len; c++) begin
            logic [6:0] o, f7;
            logic [2:0] f;
            o = OpNop; f = 3'b000; f7 = 7'd0;
            if (c == 0) begin
                o = OpReg; f = f3; f7 = 7'b0000001;
            end else if (c == 1) begin
                o = op1;
            end
            runCycle(c == rsAt, o, f, f7, $urandom, $urandom, (c >= stFrom) && (c < stTo),
                     c == flAt, 1'b1);
            sTrace[c] = {MdStartE, MdStallReq};
            wTrace[c] = {RegWriteW, ResultSrcW};
            starts += int'(MdStartE);
            stalls += int'(MdStallReq);
            if (firstM < 0 && RegWriteM) firstM = c;
            if (firstW < 0 && RegWriteW) begin
                firstW = c;
                resW   = ResultSrcW;
            end
        end
    endtask

    initial begin
        logic [6:0]  baseOps [11];
        logic [6:0]  o, f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          pick;
        baseOps = '{OpLoad, OpStore, OpReg, OpImm, OpBranch, OpJal, OpJalr, OpLui, OpAuipc,
                    OpNop, 7'b1111111};

        // Reset held two cycles with an R-type opcode presented.
        runCycle(1'b1, OpReg, 3'b000, 7'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        runCycle(1'b1, OpReg, 3'b000, 7'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkVal("rst_outs", 32'({ImmSrcD, ALUControlE, ALUSrcAE, ALUSrcBE, PCJalSrcE, PCSrcE,
                                  ResultSrcEb0, MdStartE, MdOpE, MdStallReq, RegWriteM,
                                  MemWriteM, MemWidthM, RegWriteW, ResultSrcW}), 32'd0);
        runCycle(1'b0, OpReg, 3'b000, 7'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        checkVal("rst_lat_early", 32'(RegWriteW), 32'd0);
        idle(1);
        checkVal("rst_lat", 32'(RegWriteW), 32'd1);

        // Branch conditions.
        branchCase("bltu_taken", 3'b110, 32'd1, 32'd2, 1'b1);
        branchCase("bge_nv", 3'b101, 32'h7fffffff, 32'hffffffff, 1'b1);
        branchCase("f3_010", 3'b010, 32'd5, 32'd5, 1'b0);
        branchCase("beq_ne", 3'b000, 32'd5, 32'd6, 1'b0);
        branchCase("blt_neg", 3'b100, 32'hfffffff0, 32'd3, 1'b1);
        idle(2);

        // DIV, unstalled.
        mdSeq(3'b100, OpNop, -1, -1, -1, -1, 40);
        checkVal("div_starts", 32'(starts), 32'd1);
        checkVal("div_stalls", 32'(stalls), 32'd32);
        checkVal("div_m_at", 32'(firstM), 32'd34);
        checkVal("div_w_at", 32'(firstW), 32'd35);
        checkVal("div_w_src", 32'(resW), 32'd3);

        // Single-cycle MUL followed by ADD.
        mdSeq(3'b000, OpReg, -1, -1, -1, -1, 8);
        checkVal("mul_stalls", 32'(stalls), 32'd0);
        checkVal("mul_w_at", 32'(firstW), 32'd3);
        checkVal("mul_w_src", 32'(resW), 32'd3);
        checkVal("add_w_next", 32'(wTrace[4]), 32'b100);

        // DIV finishing under a three-cycle external stall.
        mdSeq(3'b101, OpNop, 33, 36, -1, -1, 42);
        checkVal("dstl_starts", 32'(starts), 32'd1);
        checkVal("dstl_stalls", 32'(stalls), 32'd32);
        checkVal("dstl_m_at", 32'(firstM), 32'd37);
        checkVal("dstl_parked", 32'(sTrace[35]), 32'd0);

        // Flush while busy at count 5.
        mdSeq(3'b110, OpNop, -1, -1, 6, -1, 12);
        checkVal("fl_before", 32'(sTrace[6]), 32'b01);
        checkVal("fl_after", 32'(sTrace[7]), 32'b00);
        checkVal("fl_no_wb", 32'(firstW), 32'hffffffff);

        // Reset while busy.
        mdSeq(3'b111, OpNop, -1, -1, -1, 4, 10);
        checkVal("rs_stall", 32'(sTrace[5]), 32'b00);
        checkVal("rs_starts", 32'(starts), 32'd1);
        checkVal("rs_no_wb", 32'(firstW), 32'hffffffff);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            pick = int'($urandom_range(0, 13));
            f3   = 3'($urandom_range(0, 7));
            if (pick >= 11) begin
                o  = OpReg;
                f7 = 7'b0000001;
            end else begin
                o  = baseOps[pick];
                f7 = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0100000;
            end
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            runCycle($urandom_range(0, 299) == 0, o, f3, f7, a, b, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 19) == 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_md.md
# pipe_ctrl_md

Pipelined RV32IM control unit, parameterised successor to the current five-stage controller. It decodes the instruction in Decode and carries control through the Execute, Memory and Writeback control registers. It resolves all six conditional branch types in Execute from ALU flags. It sequences multi-cycle M-extension operations in Execute, asserting a stall request to the hazard unit until the operation completes.

## Interface
Parameters:
- MUL_CYCLES, 2: Execute-stage occupancy of MUL/MULH/MULHSU/MULHU, ≥1.
- DIV_CYCLES, 33: Execute-stage occupancy of DIV/DIVU/REM/REMU, ≥1, ≥MUL_CYCLES.
- ALUC_W, 4: width of ALUControl.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; one clock; all registers clear on the rising clk edge while high.
- op  in  7  Decode opcode.
- funct3  in  3  Decode funct3.
- funct7  in  7  Decode funct7; bit 5 for ALU decode, bit 0 for M-ext detect.
- ZeroE, NegE, OverflowE, CarryE  in  1 each  ALU flags of a−b in Execute; CarryE=1 means no borrow.
- FlushE  in  1  hazard unit: bubble Execute control register.
- StallE  in  1  hazard unit: hold Execute control register.
- ImmSrcD  out  3  immediate select, combinational from Decode.
- ALUControlE  out  ALUC_W  ALU operation.
- ALUSrcAE  out  1;  ALUSrcBE  out  2;  PCJalSrcE  out  1  operand/target selects.
- PCSrcE  out  1  redirect PC (taken branch or jump).
- ResultSrcEb0  out  1  ResultSrcE[0], for load-use detection.
- MdStartE  out  1  one-cycle pulse, start multiply/divide datapath.
- MdOpE  out  3  registered funct3 of the M-ext instruction.
- MdStallReq  out  1  hold Fetch/Decode/Execute this cycle.
- RegWriteM, MemWriteM  out  1 each;  MemWidthM  out  3  load/store funct3.
- RegWriteW  out  1;  ResultSrcW  out  2  00 ALU, 01 memory, 10 PC+4, 11 mul/div result.

## Operation
- Decode: base RV32I fields use the team's standard main/ALU decode.
- M-ext is op=0110011 with funct7=0000001. It sets RegWrite=1, ResultSrc=11, MemWrite=0, Branch=Jump=0 and an MdValid bit.
- Execute control register priority: reset > FlushE (all-zero bubble) > hold (StallE | MdStallReq) > load from Decode.
- Memory control register priority: reset > load a bubble when Execute is held > load from Execute.
- Writeback control register always loads from Memory.
- Branch condition on funct3:
  - 000: ZeroE.
  - 001: !ZeroE.
  - 100: NegE^OverflowE.
  - 101: !(NegE^OverflowE).
  - 110: !CarryE.
  - 111: CarryE.
  - 010/011: never taken.
- PCSrcE = JumpE | (BranchE & cond).
- MD FSM states: IDLE, BUSY, DONE. Counter width $clog2(DIV_CYCLES+1).
- N = MUL_CYCLES when funct3[2]=0, else DIV_CYCLES.
- IDLE, MdValidE=1: MdStartE=1. If N=1, the instruction completes this cycle: no stall, and go to DONE if StallE=1. If N>1: MdStallReq=1, cnt←1, go to BUSY.
- BUSY: MdStallReq=1 while cnt<N−1, cnt increments. At cnt=N−1: MdStallReq=0, go to IDLE, or to DONE if StallE=1.
- DONE: MdStallReq=0, no MdStartE. Return to IDLE on the first cycle StallE=0, so the held instruction is not restarted.
- FlushE in BUSY or DONE: abort. Next state IDLE, cnt←0; the Execute register takes the bubble.
- FlushE with an M-ext instruction arriving in Decode: no start.

## Timing
- Reset values: every registered output is 0, FSM is IDLE, cnt is 0. ResultSrcW=00 and PCSrcE=0 after reset.
- Decode-to-Writeback control latency: 3 cycles when unstalled.
- An M-ext instruction occupies Execute exactly N cycles, plus any external StallE cycles. MdStallReq is high for N−1 consecutive cycles.
- The Memory stage sees N−1 bubbles (RegWriteM=0, MemWriteM=0), then the instruction.
- MdStartE is high only in the first Execute cycle, never again for the same instruction.
- PCSrcE, ALUControlE and the other Execute outputs are combinational from the Execute register and are valid the same cycle.
- Back-to-back M-ext instructions: the second enters Execute the cycle after the first completes and starts from IDLE with no gap.
- Reset during BUSY: FSM is IDLE and MdStallReq=0 on the next cycle.

## Test plan
- Reset held 2 cycles while op=0110011 is presented → all outputs 0; first instruction reaches RegWriteW 3 cycles after release.
- BLTU with CarryE=0 → PCSrcE=1. BGE with NegE=1, OverflowE=1 → PCSrcE=1. funct3=010 → PCSrcE=0.
- DIV with DIV_CYCLES=33 → MdStartE pulses once, MdStallReq high 32 cycles, 32 Memory-stage bubbles, then RegWriteW=1 with ResultSrcW=11.
- MUL with MUL_CYCLES=1 followed by ADD → no stall; the two instructions reach Writeback on consecutive cycles.
- DIV completes while StallE=1 for 3 cycles → FSM enters DONE, no second MdStartE, and the instruction advances when StallE drops.
- FlushE at BUSY cnt=5 → next cycle FSM is IDLE, MdStallReq=0, and the Execute register is a bubble.
